// File: rtl/mem_stage_pkg.sv
// Shared types and funct3 decode helpers for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic int unsigned size_bytes(input logic [2:0] funct3);
    return 32'd1 << funct3[1:0];
  endfunction

  // Load-side legality; stores additionally reject funct3[2]=1 at the call site.
  function automatic logic is_legal(input logic [2:0] funct3, input int unsigned dw);
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      F3_D, F3_WU:                    return dw == 64;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Shifts a full-width read response down to the addressed lane and extends it per funct3.
module load_align_ext
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]              rsp_data_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    offset_i,
  input  logic [2:0]                         funct3_i,
  output logic [DATA_WIDTH-1:0]              result_o
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted  = rsp_data_i >> {offset_i, 3'b000};
    result_o = shifted;
    case (funct3_i)
      F3_B:    result_o = DATA_WIDTH'($signed(shifted[7:0]));
      F3_H:    result_o = DATA_WIDTH'($signed(shifted[15:0]));
      F3_W:    result_o = DATA_WIDTH'($signed(shifted[31:0]));
      F3_BU:   result_o = DATA_WIDTH'(shifted[7:0]);
      F3_HU:   result_o = DATA_WIDTH'(shifted[15:0]);
      F3_WU:   result_o = DATA_WIDTH'(shifted[31:0]);
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: valid/ready memory port with lanes, extension, fault and timeout.
// Optional perf counters enabled by defining MEM_STAGE_PERF_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  input  logic                    i_req_wr,
  input  logic [2:0]              i_req_funct3,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  output logic                    o_stall,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_done,
  output logic                    o_fault,
  output logic                    o_timeout,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_wr_en,
  output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_mem_byte_en,
  input  logic                    i_mem_rsp_valid,
`ifdef MEM_STAGE_PERF_EN
  output logic [31:0]             o_perf_access_cnt,
  output logic [31:0]             o_perf_stall_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rd_q, rd_d, rsp_ext;
  logic [NB-1:0]         be_q, be_d;
  logic [OFFW-1:0]       off_q, off_d, req_off;
  logic [2:0]            f3_q, f3_d;
  logic                  wr_q, wr_d, fault_q, fault_d, to_q, to_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_cycle;
  int unsigned           req_bytes;
  logic                  req_fault;

  always_comb begin
    req_off   = i_addr[OFFW-1:0];
    req_bytes = size_bytes(i_req_funct3);
    req_fault = !is_legal(i_req_funct3, DATA_WIDTH) || (i_req_wr && i_req_funct3[2]) ||
                ((32'(req_off) & (req_bytes - 32'd1)) != 32'd0);
  end

  assign last_cycle = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  load_align_ext #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rsp_data_i (i_mem_rsp_data),
    .offset_i   (off_q),
    .funct3_i   (f3_q),
    .result_o   (rsp_ext)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    to_d    = to_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (i_req_valid) begin
        addr_d  = i_addr & ~ADDR_WIDTH'(NB - 1);
        wdata_d = i_wr_data << {req_off, 3'b000};
        be_d    = NB'((32'd1 << req_bytes) - 32'd1) << req_off;
        off_d   = req_off;
        f3_d    = i_req_funct3;
        wr_d    = i_req_wr;
        fault_d = req_fault;
        to_d    = 1'b0;
        rd_d    = '0;
        cnt_d   = '0;
        state_d = req_fault ? DONE : REQ;
      end
      // A load accepted on the final budgeted cycle still times out: its response could not arrive in budget.
      REQ: begin
        if (i_mem_req_ready && wr_q) begin
          state_d = DONE;
        end else if (last_cycle) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (i_mem_req_ready) state_d = RSP;
        end
      end
      RSP: begin
        if (i_mem_rsp_valid) begin
          rd_d    = rsp_ext;
          state_d = DONE;
        end else if (last_cycle) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      to_q    <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      to_q    <= to_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_stall         = (state_q == IDLE && i_req_valid) || state_q == REQ || state_q == RSP;
  assign o_done          = (state_q == DONE);
  assign o_fault         = o_done && fault_q;
  assign o_timeout       = o_done && to_q;
  assign o_rd_data       = o_done ? rd_q : '0;
  assign o_mem_req_valid = (state_q == REQ);
  assign o_mem_addr      = o_mem_req_valid ? addr_q : '0;
  assign o_mem_wr_en     = o_mem_req_valid && wr_q;
  assign o_mem_wr_data   = o_mem_req_valid ? wdata_q : '0;
  assign o_mem_byte_en   = o_mem_req_valid ? be_q : '0;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] acc_cnt_q, stall_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (o_done && acc_cnt_q != '1)    acc_cnt_q   <= acc_cnt_q + 32'd1;
      if (o_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_perf_access_cnt = acc_cnt_q;
  assign o_perf_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a cycle-schedule reference model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr, ready, rsp_valid;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rsp_data;

  logic        stall, done, fault, tmo, mreq, mwr;
  logic [31:0] rd_data, maddr, mwdata;
  logic [3:0]  mbe;
  logic        to_stall, to_done, to_fault, to_tmo, to_mreq, to_mwr;
  logic [31:0] to_rd_data, to_maddr, to_mwdata;
  logic [3:0]  to_mbe;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0] perf_acc, perf_stall, to_perf_acc, to_perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_wr(req_wr),
    .i_req_funct3(f3), .i_addr(addr), .i_wr_data(wdata), .o_stall(stall),
    .o_rd_data(rd_data), .o_done(done), .o_fault(fault), .o_timeout(tmo),
    .o_mem_req_valid(mreq), .i_mem_req_ready(ready), .o_mem_addr(maddr),
    .o_mem_wr_en(mwr), .o_mem_wr_data(mwdata), .o_mem_byte_en(mbe),
    .i_mem_rsp_valid(rsp_valid),
`ifdef MEM_STAGE_PERF_EN
    .o_perf_access_cnt(perf_acc), .o_perf_stall_cnt(perf_stall),
`endif
    .i_mem_rsp_data(rsp_data)
  );

  mem_stage_ctrl #(.TIMEOUT_CYCLES(8)) dut_to (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_wr(req_wr),
    .i_req_funct3(f3), .i_addr(addr), .i_wr_data(wdata), .o_stall(to_stall),
    .o_rd_data(to_rd_data), .o_done(to_done), .o_fault(to_fault), .o_timeout(to_tmo),
    .o_mem_req_valid(to_mreq), .i_mem_req_ready(ready), .o_mem_addr(to_maddr),
    .o_mem_wr_en(to_mwr), .o_mem_wr_data(to_mwdata), .o_mem_byte_en(to_mbe),
    .i_mem_rsp_valid(rsp_valid),
`ifdef MEM_STAGE_PERF_EN
    .o_perf_access_cnt(to_perf_acc), .o_perf_stall_cnt(to_perf_stall),
`endif
    .i_mem_rsp_data(rsp_data)
  );

  // One access from IDLE: request in cycle 0, ready after rdly stalled REQ cycles,
  // response sdly cycles after the earliest legal response cycle.
  task automatic run_access(input logic wr, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] wd, input int rdly, input int sdly,
                            input logic [31:0] rdat);
    int          nb, off, done_cyc, req_hi, rsp_cyc;
    bit          legal, flt, in_req, in_rsp;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    longint      v, m;
    nb     = 1 << fn[1:0];
    off    = a % 4;
    legal  = wr ? (fn < 3) : (fn == 0 || fn == 1 || fn == 2 || fn == 4 || fn == 5);
    flt    = !legal || (off % nb != 0);
    e_addr = a - off;
    e_be   = 4'(((1 << nb) - 1) << off);
    e_wd   = wd << (8 * off);
    e_rd   = 32'd0;
    if (flt) begin
      done_cyc = 1; req_hi = 0; rsp_cyc = -1;
    end else if (wr) begin
      req_hi = 1 + rdly; done_cyc = req_hi + 1; rsp_cyc = -1;
    end else begin
      req_hi = 1 + rdly; rsp_cyc = req_hi + 1 + sdly; done_cyc = rsp_cyc + 1;
      m = (64'd1 << (8 * nb)) - 1;
      v = (longint'(rdat) >> (8 * off)) & m;
      if (fn < 4 && nb < 4 && v > m / 2) v = v - (m + 1);
      e_rd = 32'(v);
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; f3 = fn; addr = a; wdata = wd;
    ready = 1'b0; rsp_valid = 1'b0; rsp_data = $urandom;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || done !== 1'b0 || mreq !== 1'b0) begin
      errors++;
      $display("FAIL req_cycle0 fn=%0d a=%h: stall=%b done=%b mreq=%b want stall=1 done=0 mreq=0",
               fn, a, stall, done, mreq);
    end

    for (int cyc = 1; cyc <= done_cyc; cyc++) begin
      @(posedge clk); #1;
      in_req = (cyc <= req_hi);
      in_rsp = (rsp_cyc > 0 && cyc > req_hi && cyc < done_cyc);
      // captured fields must not follow the live request inputs
      addr = $urandom; wdata = $urandom; f3 = 3'($urandom); req_wr = 1'($urandom);
      ready    = (cyc == req_hi) ? 1'b1 : (in_req ? 1'b0 : 1'($urandom));
      rsp_data = $urandom;
      if (cyc == rsp_cyc) begin
        rsp_valid = 1'b1; rsp_data = rdat;
      end else begin
        rsp_valid = in_rsp ? 1'b0 : 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if (stall !== (cyc < done_cyc) || done !== (cyc == done_cyc) || mreq !== in_req) begin
        errors++;
        $display("FAIL handshake fn=%0d a=%h cyc%0d: stall=%b done=%b mreq=%b want %b %b %b",
                 fn, a, cyc, stall, done, mreq, cyc < done_cyc, cyc == done_cyc, in_req);
      end
      if (in_req) begin
        checks++;
        if (maddr !== e_addr || mbe !== e_be || mwr !== wr || (wr && mwdata !== e_wd)) begin
          errors++;
          $display("FAIL req_fields fn=%0d a=%h cyc%0d: addr=%h be=%b wr=%b wd=%h want %h %b %b %h",
                   fn, a, cyc, maddr, mbe, mwr, mwdata, e_addr, e_be, wr, e_wd);
        end
      end
      if (cyc == done_cyc) begin
        checks++;
        if (fault !== flt || tmo !== 1'b0 || rd_data !== e_rd) begin
          errors++;
          $display("FAIL done_result fn=%0d a=%h wr=%b: fault=%b tmo=%b rd=%h want %b 0 %h",
                   fn, a, wr, fault, tmo, rd_data, flt, e_rd);
        end
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_valid = 1'b0; ready = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; ready = 1'b0; rsp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; f3 = 3'd0; addr = '0; wdata = '0;
    ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || tmo !== 1'b0 || mreq !== 1'b0 ||
        rd_data !== 32'd0 || maddr !== 32'd0 || mwr !== 1'b0 || mwdata !== 32'd0 || mbe !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b done=%b fault=%b tmo=%b mreq=%b rd=%h addr=%h want all 0",
               stall, done, fault, tmo, mreq, rd_data, maddr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    run_access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
  endtask

  task automatic test_store_byte();
    run_access(1'b1, 3'd0, 32'h13, 32'h000000A5, 0, 0, 32'h0);
  endtask

  task automatic test_load_half();
    run_access(1'b0, 3'd1, 32'h12, 32'h0, 0, 0, 32'h8001_1234);
    run_access(1'b0, 3'd5, 32'h12, 32'h0, 1, 1, 32'h8001_1234);
    run_access(1'b0, 3'd0, 32'h11, 32'h0, 0, 0, 32'h0000_8000);
  endtask

  task automatic test_fault();
    run_access(1'b0, 3'd2, 32'h06, 32'h0, 0, 0, 32'h0);
    run_access(1'b1, 3'd3, 32'h08, 32'h1234, 0, 0, 32'h0);
    run_access(1'b0, 3'd7, 32'h00, 32'h0, 0, 0, 32'h0);
    run_access(1'b0, 3'd6, 32'h04, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_stalled_load();
    run_access(1'b0, 3'd2, 32'h40, 32'h0, 5, 2, 32'hCAFE_F00D);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int unsigned i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom % 2) a = a & ~32'h3;
      run_access(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom);
    end
    go_idle();
  endtask

  task automatic test_timeout();
    for (int unsigned pass = 0; pass < 2; pass++) begin
      do_reset();
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = 1'b0; f3 = 3'd2; addr = 32'h20; ready = 1'b0; rsp_valid = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(posedge clk); #1;
        ready = (pass == 0 && cyc == 1);
        if (cyc == 10) req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (to_done !== (cyc == 9) || to_tmo !== (cyc == 9) || to_stall !== (cyc < 9) ||
            to_fault !== 1'b0 || to_rd_data !== 32'd0 ||
            to_mreq !== (pass == 0 ? cyc == 1 : cyc <= 8)) begin
          errors++;
          $display("FAIL timeout p%0d cyc%0d: done=%b tmo=%b stall=%b mreq=%b rd=%h",
                   pass, cyc, to_done, to_tmo, to_stall, to_mreq, to_rd_data);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; f3 = 3'd2; addr = 32'h30; ready = 1'b0; rsp_valid = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_in_rsp: stall=%b want 1", stall);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || mreq !== 1'b0 || rd_data !== 32'd0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: stall=%b done=%b mreq=%b rd=%h tmo=%b want all 0",
               stall, done, mreq, rd_data, tmo);
    end
    @(posedge clk); #1;
    rst = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1111_2222;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || stall !== 1'b0 || rd_data !== 32'd0 || mreq !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_late_rsp cyc%0d: done=%b stall=%b rd=%h mreq=%b want 0",
                 cyc, done, stall, rd_data, mreq);
      end
      @(posedge clk); #1;
      rsp_valid = 1'b0;
    end
`ifdef MEM_STAGE_PERF_EN
    checks++;
    if (perf_acc !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL perf_after_reset: acc=%h stall=%h want 0", perf_acc, perf_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_half();
    test_fault();
    test_stalled_load();
    go_idle();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
